// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq: operands and start in, registered result,
// flags and the busy/done handshake out.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] hi;
    logic             co;
    logic             slt;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, ci,
        input  r, hi, co, slt, zero, busy, done
    );

    modport slave (
        input  start, op, a, b, ci,
        output r, hi, co, slt, zero, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with start/done handshake; MUL runs as a WIDTH-cycle
// unsigned shift-add, every other op completes in one cycle.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input logic     clk,
    input logic     reset,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100,
        OP_RSV = 3'b101,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } op_e;

    typedef enum logic {IDLE, MUL_RUN} state_e;

    op_e                op;
    state_e             state, state_nx;
    logic [CW-1:0]      count, count_nx;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     psum;
    logic               load_mul;

    // Single-cycle datapath
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [WIDTH-1:0] alu_r;
    logic             alu_co, alu_slt;

    // Result staging, written into the output registers on a done cycle
    logic             res_we;
    logic [WIDTH-1:0] r_nx, hi_nx;
    logic             co_nx, slt_nx;

    assign op = op_e'(bus.op);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        bx      = (op == OP_SUB || op == OP_SLT) ? ~bus.b : bus.b;
        sum     = {1'b0, bus.a} + {1'b0, bx} + {{WIDTH{1'b0}}, bus.ci};
        ovf     = (bus.a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        alu_r   = '0;
        alu_co  = 1'b0;
        alu_slt = 1'b0;
        unique case (op)
            OP_AND: alu_r = bus.a & bus.b;
            OP_OR:  alu_r = bus.a | bus.b;
            OP_XOR: alu_r = bus.a ^ bus.b;
            OP_ADD, OP_SUB: begin
                alu_r  = sum[WIDTH-1:0];
                alu_co = sum[WIDTH];
            end
            OP_SLT: begin
                alu_r   = sum[WIDTH-1:0];
                alu_co  = sum[WIDTH];
                alu_slt = sum[WIDTH-1] ^ ovf;
            end
            OP_MUL, OP_RSV: alu_r = '0;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand into the upper half,
    // then shift the whole accumulator right; the multiplier drains out of the low half.
    always_comb begin
        psum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        acc_step = acc[0] ? {psum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        load_mul = 1'b0;
        res_we   = 1'b0;
        r_nx     = '0;
        hi_nx    = '0;
        co_nx    = 1'b0;
        slt_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (op == OP_MUL) begin
                        load_mul = 1'b1;
                        count_nx = CW'(WIDTH);
                        state_nx = MUL_RUN;
                    end else begin
                        res_we = 1'b1;
                        r_nx   = alu_r;
                        co_nx  = alu_co;
                        slt_nx = alu_slt;
                    end
                end
            end
            MUL_RUN: begin
                count_nx = count - CW'(1);
                if (count == CW'(1)) begin
                    state_nx = IDLE;
                    res_we   = 1'b1;
                    r_nx     = acc_step[WIDTH-1:0];
                    hi_nx    = acc_step[2*WIDTH-1:WIDTH];
                    co_nx    = |acc_step[2*WIDTH-1:WIDTH];
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            bus.r    <= '0;
            bus.hi   <= '0;
            bus.co   <= 1'b0;
            bus.slt  <= 1'b0;
            bus.zero <= 1'b1;
            bus.done <= 1'b0;
        end else begin
            state    <= state_nx;
            count    <= count_nx;
            bus.done <= res_we;
            if (res_we) begin
                bus.r    <= r_nx;
                bus.hi   <= hi_nx;
                bus.co   <= co_nx;
                bus.slt  <= slt_nx;
                bus.zero <= (r_nx == '0);
            end
        end
    end

    // NOTE: multiplier datapath registers carry no reset; they are always loaded at acceptance before use.
    always_ff @(posedge clk) begin
        if (load_mul) begin
            acc   <= {{WIDTH{1'b0}}, bus.b};
            mcand <= bus.a;
        end else if (state == MUL_RUN) begin
            acc <= acc_step;
        end
    end

    assign bus.busy = (state == MUL_RUN);

endmodule
